// File: rtl/simplez_pkg.sv
// Shared Simplez bus constants, I/O map and serial FSM states.
// Used by the screen port and the future keyboard port.
package simplez_pkg;

  localparam int unsigned ADDRW = 9;
  localparam int unsigned DATAW = 12;

  localparam int unsigned ADDR_KBD_STATUS = 508;
  localparam int unsigned ADDR_KBD_DATA   = 509;
  localparam int unsigned ADDR_SCR_STATUS = 510;
  localparam int unsigned ADDR_SCR_DATA   = 511;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

endpackage

// File: rtl/simplez_screen_if.sv
// CPU bus view of the screen port plus its serial/status outputs.
// master = CPU side, slave = peripheral side.
interface simplez_screen_if
  import simplez_pkg::*;
#(
  parameter int unsigned AW = ADDRW,
  parameter int unsigned DW = DATAW
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] data_in;
  logic          sel;
  logic [DW-1:0] data_out;
  logic          tx;
  logic          busy;

  modport master (
    output addr, rd, wr, data_in,
    input  sel, data_out, tx, busy
  );

  modport slave (
    input  addr, rd, wr, data_in,
    output sel, data_out, tx, busy
  );
endinterface

// File: rtl/baud_tick.sv
// Bit-period divider: one-cycle tick every BAUD_DIV enabled cycles.
// Held at zero while disabled so each frame starts a full bit.
module baud_tick #(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/simplez_screen.sv
// Simplez memory-mapped screen port: status/data registers
// and an 8N1 transmitter driven from a registered tx line.
module simplez_screen #(
  parameter int unsigned ADDRW       = simplez_pkg::ADDRW,
  parameter int unsigned DATAW       = simplez_pkg::DATAW,
  parameter int unsigned BAUD_DIV    = 104,
  parameter int unsigned ADDR_STATUS = simplez_pkg::ADDR_SCR_STATUS,
  parameter int unsigned ADDR_DATA   = simplez_pkg::ADDR_SCR_DATA
) (
  input  logic clk,
  input  logic rst,
  simplez_screen_if.slave bus
);
  simplez_pkg::state_e state_q, state_d;

  logic [7:0]       byte_q, byte_d;
  logic [2:0]       bit_q, bit_d, bit_nxt;
  logic             tx_q, tx_d;
  logic             ovr_q, ovr_d;
  logic [DATAW-1:0] dout_q, dout_d;
  logic [DATAW-1:0] st_word, dt_word;
  logic             tick, hit_st, hit_dt, wr_dt;
  logic             ready, stop_end, accept, reject;
  logic             unused_hi;

  baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != simplez_pkg::S_IDLE),
    .tick (tick)
  );

  assign hit_st = bus.addr == ADDRW'(ADDR_STATUS);
  assign hit_dt = bus.addr == ADDRW'(ADDR_DATA);
  assign wr_dt  = bus.wr && hit_dt;
  assign ready  = state_q == simplez_pkg::S_IDLE;

  // the last stop tick doubles as ready so frames can abut
  assign stop_end = (state_q == simplez_pkg::S_STOP) && tick;
  assign accept   = wr_dt && (ready || stop_end);
  assign reject   = wr_dt && !accept;

  assign bit_nxt = bit_q + 3'd1;
  assign st_word = {{(DATAW-2){1'b0}}, ovr_q, ready};
  assign dt_word = {{(DATAW-8){1'b0}}, byte_q};
  assign unused_hi = ^bus.data_in[DATAW-1:8];

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    byte_d  = byte_q;
    ovr_d   = ovr_q;
    dout_d  = dout_q;
    if (bus.rd) begin
      dout_d = hit_st ? st_word :
               hit_dt ? dt_word : '0;
    end
    if (bus.rd && hit_st) ovr_d = 1'b0;
    if (reject) ovr_d = 1'b1;
    if (accept) begin
      state_d = simplez_pkg::S_START;
      tx_d    = 1'b0;
      bit_d   = 3'd0;
      byte_d  = bus.data_in[7:0];
    end else if (tick) begin
      unique case (state_q)
        simplez_pkg::S_IDLE: ;
        simplez_pkg::S_START: begin
          state_d = simplez_pkg::S_DATA;
          tx_d    = byte_q[0];
        end
        simplez_pkg::S_DATA: begin
          if (bit_q == 3'd7) begin
            state_d = simplez_pkg::S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = byte_q[bit_nxt];
          end
        end
        simplez_pkg::S_STOP: state_d = simplez_pkg::S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= simplez_pkg::S_IDLE;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      byte_q  <= 8'd0;
      ovr_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      byte_q  <= byte_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.sel      = hit_st || hit_dt;
  assign bus.data_out = dout_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = !ready;
endmodule

// File: tb/tb_simplez_screen.sv
// Directed + random bench for simplez_screen with BAUD_DIV = 4,
// checked against a frame-timing model of the serial line.
module tb_simplez_screen;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  simplez_screen_if #(.AW(9), .DW(12)) bus ();

  simplez_screen #(.BAUD_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // model: one frame descriptor, overrun flag, last accepted byte
  bit         m_have = 1'b0;
  int         fstart = 0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] m_last = 8'd0;
  bit         m_ovr = 1'b0;
  logic [11:0] m_dout = 12'd0;

  function automatic bit busy_at(input int e);
    return m_have && (e - fstart) >= 0 && (e - fstart) < 10 * B;
  endfunction

  function automatic logic tx_at(input int e);
    int slot;
    if (!busy_at(e)) return 1'b1;
    slot = (e - fstart) / B;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0;
    m_ovr  = 1'b0;
    m_last = 8'd0;
    m_dout = 12'd0;
  endtask

  // drive at negedge, model the upcoming edge, check at next negedge
  task automatic step(input logic r, input logic w,
                      input logic [8:0] a, input logic [11:0] d);
    int p;
    bit bb, dw, acc;
    bus.rd = r;
    bus.wr = w;
    bus.addr = a;
    bus.data_in = d;
    #1;
    chk("sel", bus.sel, (a == 9'd510 || a == 9'd511));
    p  = cyc + 1;
    bb = busy_at(p - 1);
    dw = w && a == 9'd511;
    acc = dw && (!bb || (p - fstart == 10 * B));
    if (r) begin
      if (a == 9'd510) m_dout = {10'd0, m_ovr, !bb};
      else if (a == 9'd511) m_dout = {4'd0, m_last};
      else m_dout = 12'd0;
    end
    if (r && a == 9'd510) m_ovr = 1'b0;
    if (dw && !acc) m_ovr = 1'b1;
    if (acc) begin
      m_have = 1'b1;
      fstart = p;
      m_byte = d[7:0];
      m_last = d[7:0];
    end
    @(posedge clk);
    @(negedge clk);
    chk("tx", bus.tx, tx_at(cyc));
    chk("busy", bus.busy, busy_at(cyc));
    chk("data_out", bus.data_out, m_dout);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'd0, 12'd0);
  endtask

  initial begin
    logic [9:0] got;
    int guard;
    logic [8:0] a;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", bus.tx, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dout", bus.data_out, 12'h000);
    rst = 1'b0;
    step(1'b1, 1'b0, 9'd510, 12'd0);
    chk("rst_status", bus.data_out, 12'h001);

    // single byte 0x41
    step(1'b0, 1'b1, 9'd511, 12'hF41);
    got[0] = bus.tx;
    for (int i = 1; i < 10; i++) begin
      idle(B);
      got[i] = bus.tx;
    end
    chk("frame_41", got, 10'b1010000010);
    idle(3);
    chk("busy_k40", bus.busy, 1'b1);
    idle(1);
    chk("busy_k41", bus.busy, 1'b0);

    // decode
    step(1'b1, 1'b0, 9'd509, 12'd0);
    chk("sel_509", bus.sel, 1'b0);
    chk("dout_509", bus.data_out, 12'h000);
    step(1'b1, 1'b0, 9'd511, 12'd0);
    chk("dout_511", bus.data_out, 12'h041);
    step(1'b1, 1'b0, 9'd0, 12'd0);
    chk("sel_0", bus.sel, 1'b0);
    chk("dout_0", bus.data_out, 12'h000);

    // overrun
    step(1'b0, 1'b1, 9'd511, 12'h055);
    idle(9);
    step(1'b0, 1'b1, 9'd511, 12'h0AA);
    step(1'b1, 1'b0, 9'd510, 12'd0);
    chk("ovr_set", bus.data_out, 12'h002);
    step(1'b1, 1'b0, 9'd510, 12'd0);
    chk("ovr_clr", bus.data_out, 12'h000);
    guard = 0;
    while (bus.busy && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("idle_timeout", guard < 100, 1'b1);
    step(1'b1, 1'b0, 9'd510, 12'd0);
    chk("ovr_ready", bus.data_out, 12'h001);
    step(1'b1, 1'b0, 9'd511, 12'd0);
    chk("ovr_byte", bus.data_out, 12'h055);

    // back-to-back
    step(1'b0, 1'b1, 9'd511, 12'h000);
    idle(39);
    chk("b2b_stop", bus.tx, 1'b1);
    step(1'b0, 1'b1, 9'd511, 12'h0FF);
    chk("b2b_start", bus.tx, 1'b0);
    chk("b2b_busy", bus.busy, 1'b1);
    idle(42);

    // reset mid-frame, with overrun pending
    step(1'b0, 1'b1, 9'd511, 12'h0C3);
    idle(5);
    step(1'b0, 1'b1, 9'd511, 12'h011);
    idle(11);
    chk("bit3_low", bus.tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_tx", bus.tx, 1'b1);
    chk("async_busy", bus.busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 9'd510, 12'd0);
    chk("post_rst_st", bus.data_out, 12'h001);
    step(1'b1, 1'b0, 9'd511, 12'd0);
    chk("post_rst_byte", bus.data_out, 12'h000);
    step(1'b0, 1'b1, 9'd511, 12'h03C);
    idle(42);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: a = 9'd510;
        1: a = 9'd511;
        2: a = 9'd509;
        3: a = 9'd0;
        default: a = 9'($urandom_range(0, 511));
      endcase
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           a, 12'($urandom_range(0, 4095)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
